// File: rtl/fifo_credit_mc_pkg.sv
// fifo_credit_mc_pkg: shared constants, arbitration-mode report and the
// credit-slice offset helper for the multi-channel credit FIFO.
// Optional feature macro: FIFO_CREDIT_MC_PRIO_EN (channel 0 strict priority).
package fifo_credit_mc_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 8;
  localparam int NUM_CH_DEF     = 4;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_PRIO0 = 1'b1
  } arb_mode_e;

`ifdef FIFO_CREDIT_MC_PRIO_EN
  localparam arb_mode_e ARB_MODE = ARB_PRIO0;
`else
  localparam arb_mode_e ARB_MODE = ARB_RR;
`endif

  // Bit offset of channel ch inside the packed credit_count vector.
  function automatic int credit_offset(input int ch, input int addr_w);
    return ch * (addr_w + 1);
  endfunction

endpackage

// File: rtl/fifo_credit_mc_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with grant lock. The search starts at the
// RR pointer and walks upward modulo N; a locked grant is held until the
// consumer takes it, and the pointer moves to grant+1 only on advance.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          advance,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_ptr;
  logic          r_hold;
  logic [IW-1:0] r_hold_idx;
  logic          w_found;
  logic [IW-1:0] w_search_idx;

  // First requesting index at or above the RR pointer, wrapping modulo N.
  always_comb begin
    int k;
    k            = 0;
    w_found      = 1'b0;
    w_search_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(r_ptr) + i;
      if (k >= N) k = k - N;
      if (!w_found && req[k]) begin
        w_found      = 1'b1;
        w_search_idx = IW'(k);
      end
    end
  end

  assign grant_idx = r_hold ? r_hold_idx : w_search_idx;
  assign grant_oh  = (r_hold || w_found) ? (N'(1) << grant_idx) : '0;

  // Pointer advance on accept, and capture of a grant that was not taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else begin
      r_hold <= lock;
      if (lock) r_hold_idx <= grant_idx;
      if (advance) begin
        if (int'(grant_idx) == N - 1) r_ptr <= '0;
        else                          r_ptr <= grant_idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_credit_mc.sv
// fifo_credit_mc: multi-channel credit FIFO. One tagged write port feeds
// NUM_CH private queues; one read port is served by an arbiter over the
// non-empty queues. Free-slot credits and pop pulses go back upstream.
// Optional feature macro: FIFO_CREDIT_MC_PRIO_EN -- channel 0 becomes strict
// priority and channels 1..NUM_CH-1 round-robin among themselves.
module fifo_credit_mc
  import fifo_credit_mc_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int NUM_CH     = NUM_CH_DEF,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [CH_W-1:0]              rd_ch,
  output logic [NUM_CH*(ADDR_W+1)-1:0] credit_count,
  output logic [NUM_CH-1:0]            credit_return
);

  localparam int CW = ADDR_W + 1;

  logic [CW-1:0]         w_credit [NUM_CH];
  logic [DATA_WIDTH-1:0] w_head   [NUM_CH];
  logic [NUM_CH-1:0]     w_nonempty;
  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_pop;
  logic [CW-1:0]         w_credit_sel;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_lock;
  logic [CH_W-1:0]       w_grant_idx;
  logic [NUM_CH-1:0]     w_grant_oh;
  logic [NUM_CH-1:0]     r_credit_return;

  // Writes need a free slot in the addressed channel; nothing is accepted in reset.
  assign wr_ready  = rst_n && (w_credit_sel != '0);
  assign w_wr_fire = wr_valid && wr_ready;
  assign rd_valid  = |w_nonempty;
  assign w_rd_fire = rd_valid && rd_ready;
  assign w_lock    = rd_valid && !rd_ready;
  assign rd_ch     = w_grant_idx;

  // Select the credit of the write target and the head of the granted channel.
  always_comb begin
    w_credit_sel = '0;
    rd_data      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c))       w_credit_sel = w_credit[c];
      if (w_grant_idx == CH_W'(c)) rd_data      = w_head[c];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [ADDR_W-1:0]     r_wr_ptr;
      logic [ADDR_W-1:0]     r_rd_ptr;
      logic [CW-1:0]         r_occ;

      assign w_push[gi]     = w_wr_fire && (wr_ch == CH_W'(gi));
      assign w_pop[gi]      = w_rd_fire && w_grant_oh[gi];
      assign w_nonempty[gi] = (r_occ != '0);
      assign w_credit[gi]   = CW'(DEPTH) - r_occ;
      assign w_head[gi]     = r_mem[r_rd_ptr];
      assign credit_count[credit_offset(gi, ADDR_W) +: CW] = w_credit[gi];

      // Payload storage; contents need no reset because occupancy gates reads.
      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr_ptr] <= wr_data;
      end

      // Pointers wrap naturally; occupancy holds when push and pop coincide.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_occ    <= '0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
          if (w_push[gi] && !w_pop[gi])      r_occ <= r_occ + CW'(1);
          else if (w_pop[gi] && !w_push[gi]) r_occ <= r_occ - CW'(1);
        end
      end
    end
  endgenerate

  // One-cycle credit pulse on the channel that was popped.
  always_ff @(posedge clk) begin
    if (!rst_n) r_credit_return <= '0;
    else        r_credit_return <= w_pop;
  end

  assign credit_return = r_credit_return;

`ifdef FIFO_CREDIT_MC_PRIO_EN
  localparam int SUB_N = NUM_CH - 1;
  localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;

  logic [SUB_N-1:0] w_sub_oh;
  logic [SUB_W-1:0] w_sub_idx;
  logic             w_sub_lock;
  logic             r_sub_hold;

  // A stalled grant on channels 1.. must not be pre-empted by channel 0.
  assign w_sub_lock = w_lock && !w_grant_oh[0];

  rr_arbiter #(
    .N  (SUB_N),
    .IW (SUB_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (w_nonempty[NUM_CH-1:1]),
    .lock      (w_sub_lock),
    .advance   (w_rd_fire && !w_grant_oh[0]),
    .grant_oh  (w_sub_oh),
    .grant_idx (w_sub_idx)
  );

  // Remember that the round-robin group owns a stalled grant.
  always_ff @(posedge clk) begin
    if (!rst_n) r_sub_hold <= 1'b0;
    else        r_sub_hold <= w_sub_lock;
  end

  // Channel 0 wins whenever it has data and the RR group is not locked.
  always_comb begin
    w_grant_oh  = {w_sub_oh, 1'b0};
    w_grant_idx = CH_W'(w_sub_idx) + CH_W'(1);
    if (!r_sub_hold && w_nonempty[0]) begin
      w_grant_oh  = NUM_CH'(1);
      w_grant_idx = '0;
    end
  end
`else
  rr_arbiter #(
    .N  (NUM_CH),
    .IW (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (w_nonempty),
    .lock      (w_lock),
    .advance   (w_rd_fire),
    .grant_oh  (w_grant_oh),
    .grant_idx (w_grant_idx)
  );
`endif

endmodule

// File: tb/tb_fifo_credit_mc.sv
// tb_fifo_credit_mc: directed scenarios followed by random traffic, every
// cycle compared against a queue-based reference model of the FIFO.
module tb_fifo_credit_mc;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [1:0]      wr_ch = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            rd_valid;
  logic            rd_ready = 1'b0;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_ch;
  logic [NCH*CW-1:0] credit_count;
  logic [NCH-1:0]  credit_return;

  always #5 clk = ~clk;

  fifo_credit_mc #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .NUM_CH     (NCH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_ch         (wr_ch),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_ch         (rd_ch),
    .credit_count  (credit_count),
    .credit_return (credit_return)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one queue per channel plus arbitration bookkeeping.
  logic [DW-1:0] q [NCH][$];
  int            m_ptr = 0;      // next channel to search from (pure RR)
  int            m_sub = 1;      // next channel among 1..NCH-1 (priority mode)
  bit            m_hold = 0;
  int            m_hold_idx = 0;
  logic [NCH-1:0] m_cr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_grant();
    int c;
    if (m_hold) return m_hold_idx;
`ifdef FIFO_CREDIT_MC_PRIO_EN
    if (q[0].size() > 0) return 0;
    for (int i = 0; i < NCH - 1; i++) begin
      c = 1 + ((m_sub - 1 + i) % (NCH - 1));
      if (q[c].size() > 0) return c;
    end
`else
    for (int i = 0; i < NCH; i++) begin
      c = (m_ptr + i) % NCH;
      if (q[c].size() > 0) return c;
    end
`endif
    return -1;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < NCH; c++) q[c].delete();
    m_ptr = 0;
    m_sub = 1;
    m_hold = 0;
    m_hold_idx = 0;
    m_cr = '0;
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input logic rst_v, input logic wv, input int wch,
                      input logic [DW-1:0] wd, input logic rr);
    int g;
    logic exp_valid, exp_wr_ready, wf, rf;
    logic [NCH*CW-1:0] exp_cc;
    @(negedge clk);
    rst_n = rst_v; wr_valid = wv; wr_ch = wch[1:0]; wr_data = wd; rd_ready = rr;
    #1;
    g = m_grant();
    exp_valid = (g >= 0);
    exp_wr_ready = rst_v && (q[wch].size() < DEPTH);
    for (int c = 0; c < NCH; c++) exp_cc[c*CW +: CW] = CW'(DEPTH - q[c].size());
    chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
    chk("wr_ready", 64'(wr_ready), 64'(exp_wr_ready));
    chk("credit_count", 64'(credit_count), 64'(exp_cc));
    chk("credit_return", 64'(credit_return), 64'(m_cr));
    if (exp_valid) begin
      chk("rd_ch", 64'(rd_ch), 64'(g));
      chk("rd_data", 64'(rd_data), 64'(q[g][0]));
    end
    @(posedge clk);
    if (!rst_v) begin
      m_clear();
    end else begin
      wf = wv && exp_wr_ready;
      rf = exp_valid && rr;
      m_cr = '0;
      m_hold = exp_valid && !rr;
      m_hold_idx = g;
      if (rf) begin
        m_cr[g] = 1'b1;
        void'(q[g].pop_front());
        m_ptr = (g + 1) % NCH;
        if (g != 0) m_sub = (g == NCH - 1) ? 1 : g + 1;
      end
      if (wf) q[wch].push_back(wd);
    end
  endtask

  initial begin
    m_clear();
    repeat (2) @(posedge clk);

    // Idle after reset, wr_ready probed for every channel.
    for (int c = 0; c < NCH; c++) step(1, 0, c, '0, 0);

    // Fill channel 2 to the brim, one refused write, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 2, 32'h200 + i, 0);
    step(1, 1, 2, 32'hDEAD, 0);
    #1;
    chk("ch2_full_credit", 64'(credit_count[11:8]), 64'd0);
    chk("ch0_untouched_credit", 64'(credit_count[3:0]), 64'd8);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, '0, 1);

    // One word per channel, then refill ch1 and ch3.
    step(1, 1, 0, 32'hA0, 0);
    step(1, 1, 1, 32'hB1, 0);
    step(1, 1, 2, 32'hC2, 0);
    step(1, 1, 3, 32'hD3, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0, 1);
    step(1, 1, 3, 32'h33, 0);
    step(1, 1, 1, 32'h11, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 1);

    // Stalled grant on ch2 must survive a later arrival on ch0.
    step(1, 1, 2, 32'h2222, 0);
    step(1, 0, 0, '0, 0);
    step(1, 1, 0, 32'h0000_00F0, 0);
    step(1, 0, 0, '0, 0);
    #1;
    chk("lock_rd_ch", 64'(rd_ch), 64'd2);
    chk("lock_rd_data", 64'(rd_data), 64'h2222);
    step(1, 0, 0, '0, 1);
    #1;
    chk("after_lock_rd_ch", 64'(rd_ch), 64'd0);
    step(1, 0, 0, '0, 1);

    // Full ch1: simultaneous write is refused while the pop frees one slot.
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1, 32'h100 + i, 0);
    step(1, 1, 1, 32'h1FF, 1);
    #1;
    chk("full_pop_credit1", 64'(credit_count[7:4]), 64'd1);
    chk("full_pop_return", 64'(credit_return), 64'h2);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, '0, 1);

    // Streams on ch0 and ch3 with a reset in the middle.
    for (int i = 0; i < 12; i++) step(1, 1, (i % 2 == 0) ? 0 : 3, 32'h5000 + i, (i > 3));
    step(0, 1, 0, 32'hBAD, 1);
    #1;
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_credits", 64'(credit_count), 64'h8888);
    for (int i = 0; i < 4; i++) step(1, 0, i, '0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 9) < 7),
           int'($urandom_range(0, NCH - 1)),
           $urandom,
           ($urandom_range(0, 9) < 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
